// File: rtl/sci_alu_pkg.sv
// Shared types for the scientific ALU issue/capture slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DATA_W/OP_W widths, opcode_t, operand_pkt_t {a, b, opcode}, issue_state_t.
package sci_alu_pkg;

  localparam int DATA_W = 64;
  localparam int OP_W   = 4;

  typedef logic [OP_W-1:0] opcode_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    opcode_t           opcode;
  } operand_pkt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/sci_alu_op_fifo.sv
// Synchronous FIFO of operand packets.
// Latency: a pushed entry is visible on pop_dat the cycle after the push (no bypass).
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk, rst_n (async active-low), push/push_dat, pop/pop_dat, full, empty.
module sci_alu_op_fifo
  import sci_alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  operand_pkt_t push_dat,
  input  logic         pop,
  output operand_pkt_t pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra MSB on each pointer separates "full" from "empty" when the
  // index bits are equal.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  operand_pkt_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/sci_alu_issue_ctrl.sv
// Issue/capture stage around the untimed scientific_alu: buffers operands, holds them for a settle window, registers the result.
// Latency: push to out_valid = 2 + SETTLE_CYCLES cycles from idle; one result per SETTLE_CYCLES+1 cycles when out_ready is held.
// Backpressure: in_ready = !full (registered); a result waits in HOLD until out_ready, packets keep buffering meanwhile.
// Ports: in_* producer side, alu_* to/from scientific_alu, out_* consumer side.
// Optional macro SCI_ALU_STATS_EN adds parameter CNT_W and ports stats_clr, excep_cnt, err_cnt, op_cnt.
module sci_alu_issue_ctrl
  import sci_alu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
`ifdef SCI_ALU_STATS_EN
  ,
  parameter int CNT_W         = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_excep,
  input  logic              alu_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_excep,
  output logic              out_err,
  output logic [OP_W-1:0]   out_opcode
`ifdef SCI_ALU_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  excep_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  op_cnt
`endif
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

  issue_state_t    state_q;
  issue_state_t    state_d;
  operand_pkt_t    pkt_in;
  operand_pkt_t    pkt_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            capture;
  logic [SC_W-1:0] settle_cnt;

  assign pkt_in   = {in_a, in_b, in_opcode};
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;

  sci_alu_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (pkt_in),
    .pop      (pop),
    .pop_dat  (pkt_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SC_W'(1)) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Handshake cycle doubles as the pop of the next packet.
        if (out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU operands change only on a pop, so the untimed ALU sees a stable
  // input vector for the whole settle window and while the result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_excep  <= 1'b0;
      out_err    <= 1'b0;
      out_opcode <= '0;
    end else begin
      if (pop) begin
        alu_a      <= pkt_head.a;
        alu_b      <= pkt_head.b;
        alu_opcode <= pkt_head.opcode;
        settle_cnt <= SC_W'(SETTLE_CYCLES);
      end else if (state_q == SETTLE) begin
        settle_cnt <= settle_cnt - SC_W'(1);
      end

      if (capture) begin
        out_valid  <= 1'b1;
        out_result <= alu_result;
        out_excep  <= alu_excep;
        out_err    <= alu_err;
        out_opcode <= alu_opcode;
      end else if ((state_q == HOLD) && out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef SCI_ALU_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt    <= '0;
      excep_cnt <= '0;
      err_cnt   <= '0;
    end else if (stats_clr) begin
      op_cnt    <= '0;
      excep_cnt <= '0;
      err_cnt   <= '0;
    end else if (capture) begin
      op_cnt <= sat_inc(op_cnt);
      if (alu_excep) excep_cnt <= sat_inc(excep_cnt);
      if (alu_err)   err_cnt   <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_sci_alu_issue_ctrl.sv
// Self-checking bench for sci_alu_issue_ctrl with a behavioural scientific_alu model.
// Latency: n/a.
// Backpressure: exercised through randomized and held-low out_ready.
module tb_sci_alu_issue_ctrl;
  import sci_alu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [3:0]  in_opcode = '0;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_result;
  logic        alu_excep;
  logic        alu_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_excep;
  logic        out_err;
  logic [3:0]  out_opcode;
`ifdef SCI_ALU_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] excep_cnt, err_cnt, op_cnt;
  logic [3:0]  excep_cnt4, err_cnt4, op_cnt4;
  logic        in_ready4, out_valid4, out_excep4, out_err4;
  logic [63:0] alu_a4, alu_b4, out_result4;
  logic [3:0]  alu_opcode4, out_opcode4;
`endif

  always #5 clk = ~clk;

  sci_alu_issue_ctrl #(
    .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
`ifdef SCI_ALU_STATS_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_excep(alu_excep), .alu_err(alu_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_excep(out_excep), .out_err(out_err), .out_opcode(out_opcode)
`ifdef SCI_ALU_STATS_EN
    , .stats_clr(stats_clr), .excep_cnt(excep_cnt), .err_cnt(err_cnt), .op_cnt(op_cnt)
`endif
  );

`ifdef SCI_ALU_STATS_EN
  // Narrow-counter twin that shares all stimulus; only its counters are checked.
  sci_alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_opcode4),
    .alu_result(alu_result), .alu_excep(alu_excep), .alu_err(alu_err),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_excep(out_excep4), .out_err(out_err4), .out_opcode(out_opcode4),
    .stats_clr(stats_clr), .excep_cnt(excep_cnt4), .err_cnt(err_cnt4), .op_cnt(op_cnt4)
  );
`endif

  // Behavioural scientific_alu: returns {err, excep, result}.
  function automatic logic [65:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
    logic [63:0] r;
    case (op)
      4'd0:    r = $realtobits($bitstoreal(a) + $bitstoreal(b));
      4'd1:    r = $realtobits($bitstoreal(a) - $bitstoreal(b));
      4'd2:    r = $realtobits($bitstoreal(a) * $bitstoreal(b));
      default: r = (a ^ {b[31:0], b[63:32]}) + {60'd0, op};
    endcase
    return {op == 4'd15, op == 4'd4, r};
  endfunction

  always_comb {alu_err, alu_excep, alu_result} = alu_model(alu_a, alu_b, alu_opcode);

  typedef struct {
    logic [63:0] res;
    logic        excep;
    logic        err;
    logic [3:0]  op;
    int          t;
  } obs_t;

  obs_t         obs_q[$];
  operand_pkt_t pk_buf[64];
  int           in_acc = 0;
  int           cyc = 0;
  int           stable_viol = 0;
  int           tests = 0;
  int           fails = 0;
  logic         hold_prev = 1'b0;
  logic [72:0]  prev_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observers sample mid-cycle, i.e. what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) in_acc++;
      if (out_valid && out_ready)
        obs_q.push_back('{res: out_result, excep: out_excep, err: out_err, op: out_opcode, t: cyc});
      if (hold_prev && (prev_out !== {out_result, out_excep, out_err, out_opcode, out_valid}))
        stable_viol++;
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_result, out_excep, out_err, out_opcode, out_valid};
    end
  end

  function automatic operand_pkt_t rand_pkt();
    operand_pkt_t p;
    p.a      = $realtobits(real'($urandom_range(1, 4000)) / 16.0);
    p.b      = $realtobits(real'($urandom_range(1, 4000)) / 16.0);
    p.opcode = 4'($urandom_range(1, 15));
    return p;
  endfunction

  task automatic present(input operand_pkt_t p);
    in_a = p.a; in_b = p.b; in_opcode = p.opcode;
  endtask

  // Drives pk_buf[0..n-1] with random valid/ready duty until n results leave.
  task automatic run_pkts(input int n, input int vp, input int rp);
    int base = in_acc;
    int sent = 0;
    int guard = 0;
    while ((sent < n || obs_q.size() < n) && guard < 2000) begin
      if (sent < n) begin
        present(pk_buf[sent]);
        in_valid = ($urandom_range(1, 100) <= vp);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(1, 100) <= rp);
      @(posedge clk); #1;
      sent = in_acc - base;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (alu_a !== 64'd0) begin fails++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
    tests++; if (out_result !== 64'd0) begin fails++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_opcode !== 4'd0) begin fails++; $display("FAIL reset_out_opcode: got %h want 0", out_opcode); end
  endtask

  task automatic test_single_op();
    int n = 0;
    obs_q.delete();
    present('{a: 64'h4030000000000000, b: 64'h4000000000000000, opcode: 4'd0});
    in_valid = 1'b1;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    tests++; if (n != 2 + SETTLE) begin fails++; $display("FAIL single_latency: got %0d cycles want %0d", n, 2 + SETTLE); end
    tests++; if (out_result !== 64'h4032000000000000) begin fails++; $display("FAIL single_result: got %h want 4032000000000000", out_result); end
    tests++; if (out_opcode !== 4'd0 || out_excep !== 1'b0 || out_err !== 1'b0) begin
      fails++; $display("FAIL single_flags: got op=%h x=%b e=%b want op=0 x=0 e=0", out_opcode, out_excep, out_err); end
    repeat (3) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_hold: got out_valid=%b want 1", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got out_valid=%b want 0", out_valid); end
    obs_q.delete();
  endtask

  task automatic test_sweep();
    int nx = 0;
    int ne = 0;
    logic [65:0] e;
    obs_q.delete();
`ifdef SCI_ALU_STATS_EN
    stats_clr = 1'b1; @(posedge clk); #1; stats_clr = 1'b0;
`endif
    for (int i = 0; i < 16; i++) pk_buf[i] = '{a: 64'h4030000000000000, b: 64'h4000000000000000, opcode: 4'(i)};
    run_pkts(16, 100, 100);
    tests++; if (obs_q.size() != 16) begin fails++; $display("FAIL sweep_count: got %0d want 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 16; i++) begin
      e = alu_model(pk_buf[i].a, pk_buf[i].b, pk_buf[i].opcode);
      tests++;
      if (obs_q[i].res !== e[63:0] || obs_q[i].excep !== e[64] || obs_q[i].err !== e[65] || obs_q[i].op !== pk_buf[i].opcode) begin
        fails++; $display("FAIL sweep_item%0d: got op=%h r=%h x=%b e=%b want op=%h r=%h x=%b e=%b", i, obs_q[i].op,
                          obs_q[i].res, obs_q[i].excep, obs_q[i].err, pk_buf[i].opcode, e[63:0], e[64], e[65]);
      end
      if (obs_q[i].excep === 1'b1) nx++;
      if (obs_q[i].err === 1'b1) ne++;
      if (i > 0) begin
        tests++;
        if (obs_q[i].t - obs_q[i-1].t != SETTLE + 1) begin
          fails++; $display("FAIL sweep_rate%0d: got gap %0d want %0d", i, obs_q[i].t - obs_q[i-1].t, SETTLE + 1);
        end
      end
    end
    tests++; if (nx != 1 || ne != 1) begin fails++; $display("FAIL sweep_flag_counts: got excep=%0d err=%0d want 1 1", nx, ne); end
`ifdef SCI_ALU_STATS_EN
    tests++; if (op_cnt !== 16'd16 || excep_cnt !== 16'd1 || err_cnt !== 16'd1) begin
      fails++; $display("FAIL sweep_stats: got op=%0d x=%0d e=%0d want 16 1 1", op_cnt, excep_cnt, err_cnt); end
    tests++; if (op_cnt4 !== 4'd15) begin fails++; $display("FAIL sweep_stats_sat: got %0d want 15", op_cnt4); end
`endif
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    int base = in_acc;
    int k;
    int guard = 0;
    logic [65:0] e;
    obs_q.delete();
    stable_viol = 0;
    for (int i = 0; i < 6; i++) pk_buf[i] = rand_pkt();
    out_ready = 1'b0;
    repeat (15) begin
      k = in_acc - base;
      if (k < 6) begin present(pk_buf[k]); in_valid = 1'b1; end else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    tests++; if (in_acc - base != 5) begin fails++; $display("FAIL bp_accepted: got %0d want 5", in_acc - base); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_opcode !== pk_buf[0].opcode) begin
      fails++; $display("FAIL bp_head: got v=%b op=%h want v=1 op=%h", out_valid, out_opcode, pk_buf[0].opcode); end
    tests++; if (stable_viol != 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", stable_viol); end
    out_ready = 1'b1;
    while (obs_q.size() < 6 && guard < 200) begin
      k = in_acc - base;
      if (k < 6) begin present(pk_buf[k]); in_valid = 1'b1; end else in_valid = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (obs_q.size() != 6) begin fails++; $display("FAIL bp_drain: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      e = alu_model(pk_buf[i].a, pk_buf[i].b, pk_buf[i].opcode);
      tests++;
      if (obs_q[i].res !== e[63:0] || obs_q[i].op !== pk_buf[i].opcode || obs_q[i].excep !== e[64] || obs_q[i].err !== e[65]) begin
        fails++; $display("FAIL bp_item%0d: got op=%h r=%h want op=%h r=%h", i, obs_q[i].op, obs_q[i].res, pk_buf[i].opcode, e[63:0]);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [65:0] e;
    obs_q.delete();
    for (int i = 0; i < 40; i++) pk_buf[i] = rand_pkt();
    run_pkts(40, 70, 60);
    tests++; if (obs_q.size() != 40) begin fails++; $display("FAIL rand_count: got %0d want 40", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 40; i++) begin
      e = alu_model(pk_buf[i].a, pk_buf[i].b, pk_buf[i].opcode);
      tests++;
      if (obs_q[i].res !== e[63:0] || obs_q[i].op !== pk_buf[i].opcode || obs_q[i].excep !== e[64] || obs_q[i].err !== e[65]) begin
        fails++; $display("FAIL rand_item%0d: got op=%h r=%h x=%b e=%b want op=%h r=%h x=%b e=%b", i, obs_q[i].op, obs_q[i].res,
                          obs_q[i].excep, obs_q[i].err, pk_buf[i].opcode, e[63:0], e[64], e[65]);
      end
    end
    obs_q.delete();
  endtask

`ifdef SCI_ALU_STATS_EN
  task automatic test_stats();
    obs_q.delete();
    pk_buf[0] = rand_pkt();
    run_pkts(1, 100, 100);
    tests++; if (op_cnt4 !== 4'd15) begin fails++; $display("FAIL stats_sat17: got %0d want 15", op_cnt4); end
    tests++; if (op_cnt === 16'd0) begin fails++; $display("FAIL stats_pre_clr: got 0 want nonzero"); end
    stats_clr = 1'b1;
    obs_q.delete();
    pk_buf[0] = rand_pkt();
    run_pkts(1, 100, 100);
    stats_clr = 1'b0;
    tests++; if (op_cnt !== 16'd0 || op_cnt4 !== 4'd0) begin
      fails++; $display("FAIL stats_clr_prio: got %0d/%0d want 0/0", op_cnt, op_cnt4); end
    obs_q.delete();
  endtask
`endif

  task automatic test_reset_mid_op();
    int base = in_acc;
    int guard = 0;
    logic [65:0] e;
    obs_q.delete();
    for (int i = 0; i < 5; i++) pk_buf[i] = rand_pkt();
    out_ready = 1'b0;
    while (in_acc - base < 5 && guard < 40) begin
      present(pk_buf[in_acc - base]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (alu_a !== pk_buf[1].a) begin fails++; $display("FAIL mid_settle_alu_a: got %h want %h", alu_a, pk_buf[1].a); end
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_result !== 64'd0) begin
      fails++; $display("FAIL mid_rst_out: got v=%b r=%h want 0 0", out_valid, out_result); end
    tests++; if (alu_a !== 64'd0 || alu_opcode !== 4'd0) begin
      fails++; $display("FAIL mid_rst_alu: got a=%h op=%h want 0 0", alu_a, alu_opcode); end
    @(negedge clk) rst_n = 1'b1;
    obs_q.delete();
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mid_rst_stale: got %0d results want 0", obs_q.size()); end
    pk_buf[0] = rand_pkt();
    run_pkts(1, 100, 100);
    e = alu_model(pk_buf[0].a, pk_buf[0].b, pk_buf[0].opcode);
    tests++;
    if (obs_q.size() != 1 || obs_q[0].res !== e[63:0] || obs_q[0].op !== pk_buf[0].opcode) begin
      fails++; $display("FAIL mid_rst_fresh: got %0d results want 1 with op=%h r=%h", obs_q.size(), pk_buf[0].opcode, e[63:0]);
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_sweep();
    test_backpressure();
    test_random();
`ifdef SCI_ALU_STATS_EN
    test_stats();
`endif
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
